// File: rtl/systolic_result_writeback.sv
`default_nettype none
// ---------------------------------------------------------------------------
// systolic_result_writeback : saturates controller result rows, buffers them in
// a small FIFO and commits them to the output SRAM over a req/gnt handshake.
// Revision: 1.0
// ---------------------------------------------------------------------------
module systolic_result_writeback #(
  parameter int LANES      = 4,
  parameter int ACC_W      = 20,
  parameter int OUT_W      = 8,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     srstn,
  input  logic                     wb_start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic                     wr_valid,
  input  logic [5:0]               matrix_index,
  input  logic [1:0]               data_set,
  input  logic [LANES*ACC_W-1:0]   row_data,
  input  logic                     tpu_done,
  output logic                     sram_req,
  output logic [ADDR_W-1:0]        sram_addr,
  output logic [LANES*OUT_W-1:0]   sram_wdata,
  input  logic                     sram_gnt,
  output logic                     wb_done,
  output logic                     overflow,
  output logic [8:0]               write_count
);

  localparam int              PTR_W    = $clog2(FIFO_DEPTH);
  localparam int              DATA_W   = LANES * OUT_W;
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [1:0]      IDLE     = 2'd0;
  localparam logic [1:0]      ACTIVE   = 2'd1;
  localparam logic [1:0]      DRAIN    = 2'd2;

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic              done_set;
  logic [ADDR_W-1:0] base_reg;

  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_data;
  logic [DATA_W-1:0] sat_data;
  logic [ADDR_W-1:0] row_addr;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count;

  logic capture;
  logic push;
  logic push_ok;
  logic pop;
  logic fifo_empty;

  // A lane fits when every bit above the output sign bit equals that sign bit
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [ACC_W-1:0]     lane;
    logic [ACC_W-OUT_W:0] hi;
    assign lane = row_data[i*ACC_W +: ACC_W];
    assign hi   = lane[ACC_W-1:OUT_W-1];
    assign sat_data[i*OUT_W +: OUT_W] =
        ((hi == '0) || (hi == '1)) ? lane[OUT_W-1:0] :
        (lane[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}});
  end

  assign row_addr   = base_reg + ADDR_W'({data_set, matrix_index});
  assign capture    = wr_valid && (state != IDLE) && !wb_start;
  assign fifo_empty = (count == '0);
  assign pop        = !fifo_empty && sram_gnt;
  assign push       = s1_valid && !wb_start;
  assign push_ok    = push && ((count != FULL_CNT) || pop);

  assign sram_req   = !fifo_empty;
  assign sram_addr  = fifo_empty ? '0 : fifo_addr[rd_ptr];
  assign sram_wdata = fifo_empty ? '0 : fifo_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (wb_start) begin
      next_state = ACTIVE;
    end else begin
      case (state)
        ACTIVE:  if (tpu_done) next_state = DRAIN;
        DRAIN:   if (fifo_empty && !s1_valid) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    done_set = (state == DRAIN) && fifo_empty && !s1_valid && !wb_start;
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      wb_done  <= 1'b0;
      base_reg <= '0;
    end else begin
      wb_done <= done_set;
      if (wb_start) base_reg <= base_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!srstn || wb_start) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= capture;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      s1_addr <= row_addr;
      s1_data <= sat_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!srstn || wb_start) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_addr[wr_ptr] <= s1_addr;
      fifo_data[wr_ptr] <= s1_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!srstn || wb_start) begin
      overflow    <= 1'b0;
      write_count <= '0;
    end else begin
      if (push && !push_ok) overflow <= 1'b1;
      if (pop && (write_count != 9'h1FF)) write_count <= write_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_result_writeback.sv
`default_nettype none
// Randomized and directed bench for systolic_result_writeback, checked against
// a queue-based reference model of the writeback path.
module tb_systolic_result_writeback;

  localparam int LANES = 4;
  localparam int ACC_W = 20;
  localparam int OUT_W = 8;
  localparam int ADDR_W = 10;
  localparam int DEPTH = 4;

  logic                     clk = 1'b0;
  logic                     srstn;
  logic                     wb_start;
  logic [ADDR_W-1:0]        base_addr;
  logic                     wr_valid;
  logic [5:0]               matrix_index;
  logic [1:0]               data_set;
  logic [LANES*ACC_W-1:0]   row_data;
  logic                     tpu_done;
  logic                     sram_req;
  logic [ADDR_W-1:0]        sram_addr;
  logic [LANES*OUT_W-1:0]   sram_wdata;
  logic                     sram_gnt;
  logic                     wb_done;
  logic                     overflow;
  logic [8:0]               write_count;

  systolic_result_writeback dut (
    .clk(clk), .srstn(srstn), .wb_start(wb_start), .base_addr(base_addr),
    .wr_valid(wr_valid), .matrix_index(matrix_index), .data_set(data_set),
    .row_data(row_data), .tpu_done(tpu_done), .sram_req(sram_req),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_gnt(sram_gnt),
    .wb_done(wb_done), .overflow(overflow), .write_count(write_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int done_pulses = 0;

  // Reference model: committed-order queue of pending SRAM writes
  logic [ADDR_W-1:0]      q_addr[$];
  logic [LANES*OUT_W-1:0] q_data[$];
  bit                     m_s1v;
  logic [ADDR_W-1:0]      m_s1a;
  logic [LANES*OUT_W-1:0] m_s1d;
  int                     m_base;
  bit                     m_run, m_drain, m_done, m_ovf;
  int                     m_cnt;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] sat_lane(input logic [19:0] v);
    int s;
    logic [31:0] t;
    s = int'($signed(v));
    if (s > 127) return 8'h7F;
    if (s < -128) return 8'h80;
    t = s;
    return t[7:0];
  endfunction

  task automatic model_update();
    bit pre_empty, pre_s1, popd;
    pre_empty = (q_addr.size() == 0);
    pre_s1    = m_s1v;
    popd      = !pre_empty && sram_gnt;
    if (!srstn) begin
      q_addr.delete(); q_data.delete();
      m_s1v = 0; m_base = 0; m_run = 0; m_drain = 0; m_done = 0; m_ovf = 0; m_cnt = 0;
      return;
    end
    if (wb_start) begin
      q_addr.delete(); q_data.delete();
      m_s1v = 0; m_ovf = 0; m_cnt = 0; m_base = int'(base_addr);
      m_run = 1; m_drain = 0; m_done = 0;
      return;
    end
    m_done = 0;
    if (popd) begin
      void'(q_addr.pop_front());
      void'(q_data.pop_front());
      if (m_cnt < 511) m_cnt++;
    end
    if (pre_s1) begin
      if (q_addr.size() < DEPTH) begin
        q_addr.push_back(m_s1a);
        q_data.push_back(m_s1d);
      end else begin
        m_ovf = 1;
      end
    end
    if ((m_run || m_drain) && wr_valid) begin
      m_s1v = 1;
      m_s1a = ADDR_W'((m_base + int'(data_set) * 64 + int'(matrix_index)) % 1024);
      for (int i = 0; i < LANES; i++)
        m_s1d[i*OUT_W +: OUT_W] = sat_lane(row_data[i*ACC_W +: ACC_W]);
    end else begin
      m_s1v = 0;
    end
    if (m_run && tpu_done) begin
      m_run = 0; m_drain = 1;
    end else if (m_drain && pre_empty && !pre_s1) begin
      m_drain = 0; m_done = 1;
    end
  endtask

  task automatic compare_all();
    check_val("sram_req", sram_req, q_addr.size() > 0);
    if (q_addr.size() > 0) begin
      check_val("sram_addr", sram_addr, q_addr[0]);
      check_val("sram_wdata", sram_wdata, q_data[0]);
    end else begin
      check_val("sram_addr_idle", sram_addr, 0);
      check_val("sram_wdata_idle", sram_wdata, 0);
    end
    check_val("wb_done", wb_done, m_done);
    check_val("overflow", overflow, m_ovf);
    check_val("write_count", write_count, m_cnt);
    if (wb_done) done_pulses++;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    wb_start = 0; wr_valid = 0; tpu_done = 0; matrix_index = 0; data_set = 0;
    row_data = '0;
  endtask

  function automatic logic [LANES*ACC_W-1:0] rand_row();
    logic [LANES*ACC_W-1:0] r;
    logic [31:0] t;
    int s;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 2))
        0: t = $urandom();
        1: begin s = int'($urandom_range(0, 400)) - 200; t = s; end
        default: begin
          case ($urandom_range(0, 3))
            0: s = 127; 1: s = 128; 2: s = -128; default: s = -129;
          endcase
          t = s;
        end
      endcase
      r[i*ACC_W +: ACC_W] = t[ACC_W-1:0];
    end
    return r;
  endfunction

  task automatic start_run(input logic [ADDR_W-1:0] base);
    idle_inputs();
    wb_start = 1; base_addr = base;
    step();
    wb_start = 0;
  endtask

  task automatic send_row(input int ds, input int mi, input logic [LANES*ACC_W-1:0] d);
    wr_valid = 1; data_set = ds[1:0]; matrix_index = mi[5:0]; row_data = d;
    step();
    wr_valid = 0;
  endtask

  task automatic finish_run(input string tag);
    bit seen;
    idle_inputs();
    tpu_done = 1;
    step();
    tpu_done = 0;
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      step();
      if (wb_done) seen = 1;
    end
    check_val(tag, seen, 1);
  endtask

  initial begin
    idle_inputs();
    srstn = 0; base_addr = '0; sram_gnt = 0;
    repeat (3) step();
    check_val("reset_req", sram_req, 0);
    check_val("reset_count", write_count, 0);
    srstn = 1;
    step();

    // Full 128-row run with the SRAM always granting
    sram_gnt = 1;
    start_run(10'h100);
    done_pulses = 0;
    for (int i = 0; i < 128; i++) send_row(i / 64, i % 64, rand_row());
    finish_run("run1_done_timeout");
    repeat (3) step();
    check_val("run1_write_count", write_count, 128);
    check_val("run1_overflow", overflow, 0);
    check_val("run1_done_pulses", done_pulses, 1);

    // Saturation of one row of extreme lanes, plus two-cycle latency
    sram_gnt = 0;
    start_run(10'h000);
    send_row(0, 0, {20'hFFFF0, 20'h00005, 20'h80000, 20'h7FFFF});
    step();
    check_val("sat_req_latency", sram_req, 1);
    check_val("sat_wdata", sram_wdata, 32'hF005807F);
    sram_gnt = 1;
    finish_run("sat_done_timeout");

    // Backpressure: six rows into a four-entry buffer
    sram_gnt = 0;
    start_run(10'h040);
    for (int i = 0; i < 6; i++) send_row(0, i, rand_row());
    repeat (3) step();
    check_val("bp_overflow", overflow, 1);
    sram_gnt = 1;
    repeat (4) step();
    sram_gnt = 0;
    step();
    check_val("bp_write_count", write_count, 4);
    check_val("bp_req_empty", sram_req, 0);
    sram_gnt = 1;
    finish_run("bp_done_timeout");

    // Full buffer with a grant on the cycle the fifth row lands
    sram_gnt = 0;
    start_run(10'h080);
    for (int i = 0; i < 5; i++) send_row(1, i, rand_row());
    sram_gnt = 1;
    step();
    sram_gnt = 0;
    step();
    check_val("full_pushpop_overflow", overflow, 0);
    sram_gnt = 1;
    finish_run("full_done_timeout");
    check_val("full_write_count", write_count, 5);

    // Address wrap-around
    sram_gnt = 0;
    start_run(10'h3F0);
    send_row(0, 6'h20, rand_row());
    step();
    check_val("wrap_addr", sram_addr, 10'h010);
    sram_gnt = 1;
    finish_run("wrap_done_timeout");

    // Restart with three rows buffered, then a mid-run reset
    sram_gnt = 0;
    start_run(10'h000);
    for (int i = 0; i < 3; i++) send_row(0, i, rand_row());
    step();
    check_val("restart_pre_req", sram_req, 1);
    start_run(10'h200);
    check_val("restart_req", sram_req, 0);
    check_val("restart_count", write_count, 0);
    send_row(0, 5, rand_row());
    step();
    check_val("restart_new_base", sram_addr, 10'h205);
    for (int i = 0; i < 6; i++) send_row(0, i, rand_row());
    step();
    srstn = 0;
    step();
    check_val("mid_reset_req", sram_req, 0);
    check_val("mid_reset_overflow", overflow, 0);
    srstn = 1;
    step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      idle_inputs();
      wb_start = ($urandom_range(0, 199) == 0);
      base_addr = ADDR_W'($urandom());
      wr_valid = $urandom_range(0, 1);
      data_set = 2'($urandom());
      matrix_index = 6'($urandom());
      row_data = rand_row();
      tpu_done = ($urandom_range(0, 59) == 0);
      sram_gnt = ($urandom_range(0, 9) < 6);
      if (c % 500 == 0) wb_start = 1;
      step();
    end
    idle_inputs();
    sram_gnt = 1;
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
